// File: rtl/zube_wb_pkg.sv
// Purpose: shared types and default sizes for the zube Wishbone initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package zube_wb_pkg;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } zube_wb_state_e;

    localparam int ZUBE_WB_ADDR_W  = 32;
    localparam int ZUBE_WB_DATA_W  = 32;
    localparam int ZUBE_WB_TIMEOUT = 255;

    // Counter width for a timeout limit; a zero limit (never time out) still
    // gets a 1-bit counter so the declaration stays legal.
    function automatic int zube_wb_cnt_w(input int timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/zube_wb_initiator.sv
// Purpose: Wishbone classic single-transfer master; one read/write per command.
// Latency: accept edge N, cyc/stb high from N+1, rsp_valid after N+2 at best (3 cycles/command back-to-back).
// Backpressure: cmd_ready only in IDLE; response held until rsp_valid&rsp_ready.
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   cmd_valid/ready/we/addr/data - command channel (valid/ready)
//   rsp_valid/ready/data/err      - response channel (valid/ready); err = timed out
//   wb_cyc/stb/we/addr/data_out, wb_ack_in, wb_data_in - Wishbone master port
// Optional: `define ZUBE_WB_INIT_SEL_EN adds cmd_sel / wb_sel_out byte lane selects;
//   unselected lanes of read data are returned as zero.
module zube_wb_initiator
    import zube_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ZUBE_WB_ADDR_W,
    parameter int DATA_WIDTH     = ZUBE_WB_DATA_W,
    parameter int TIMEOUT_CYCLES = ZUBE_WB_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
`ifdef ZUBE_WB_INIT_SEL_EN
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    output logic [DATA_WIDTH/8-1:0] wb_sel_out,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    wb_cyc_out,
    output logic                    wb_stb_out,
    output logic                    wb_we_out,
    output logic [ADDR_WIDTH-1:0]   wb_addr_out,
    output logic [DATA_WIDTH-1:0]   wb_data_out,
    input  logic                    wb_ack_in,
    input  logic [DATA_WIDTH-1:0]   wb_data_in
);

    localparam int CNT_W   = zube_wb_cnt_w(TIMEOUT_CYCLES);
    localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    zube_wb_state_e          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rd_mask;

`ifdef ZUBE_WB_INIT_SEL_EN
    logic [DATA_WIDTH/8-1:0] sel_q, sel_d;

    // Expand byte selects into a bit mask for read data.
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            rd_mask[8*i +: 8] = {8{sel_q[i]}};
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (state_q == ST_IDLE && cmd_valid) begin
            sel_d = cmd_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= '1;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign wb_sel_out = sel_q;
`else
    // Full-word transfers only.
    assign rd_mask = '1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_data;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the last allowed cycle wins.
                if (wb_ack_in) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = we_q ? '0 : (wb_data_in & rd_mask);
                    rsp_err_d = 1'b0;
                    rsp_vld_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TO_LAST)) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_vld_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Terminates at TO_LAST, so this never wraps.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                cyc_d     = 1'b0;
                rsp_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wb_cyc_out  = cyc_q;
    assign wb_stb_out  = cyc_q;
    assign wb_we_out   = we_q;
    assign wb_addr_out = addr_q;
    assign wb_data_out = wdata_q;
    assign rsp_valid   = rsp_vld_q;
    assign rsp_data    = rsp_dat_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_zube_wb_initiator.sv
// Purpose: self-checking bench for zube_wb_initiator with a behavioural slave and reference model.
// Latency: n/a (testbench).
// Backpressure: exercises held responses via rsp_ready low periods.
module tb_zube_wb_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_data;
`ifdef ZUBE_WB_INIT_SEL_EN
    logic [3:0]  cmd_sel, wb_sel_out;
`endif
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        wb_cyc_out, wb_stb_out, wb_we_out, wb_ack_in;
    logic [31:0] wb_addr_out, wb_data_out, wb_data_in;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    zube_wb_initiator #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
`ifdef ZUBE_WB_INIT_SEL_EN
        .cmd_sel    (cmd_sel),
        .wb_sel_out (wb_sel_out),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .wb_cyc_out (wb_cyc_out),
        .wb_stb_out (wb_stb_out),
        .wb_we_out  (wb_we_out),
        .wb_addr_out(wb_addr_out),
        .wb_data_out(wb_data_out),
        .wb_ack_in  (wb_ack_in),
        .wb_data_in (wb_data_in)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One complete command. ack_dly = bus cycle index (0-based) on which the
    // slave acks, or -1 for never. hold = cycles rsp_ready stays low.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int ack_dly,
                          input logic [31:0] rdata, input int hold);
        bit          exp_err;
        int          term;
        int          k;
        bit          stable;
        logic [3:0]  eff_sel;
        logic [31:0] mask, exp_data;
        logic [33:0] rsp_snap;

        // Reference: the transfer ends on the ack cycle if it falls inside the
        // timeout window, otherwise on the last window cycle with an error.
        exp_err = !(ack_dly >= 0 && ack_dly <= TO - 1);
        term    = exp_err ? TO - 1 : ack_dly;
`ifdef ZUBE_WB_INIT_SEL_EN
        eff_sel = sel;
`else
        eff_sel = sel | 4'hF;
`endif
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{eff_sel[i]}};
        exp_data = (exp_err || we) ? 32'h0 : (rdata & mask);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
`ifdef ZUBE_WB_INIT_SEL_EN
        cmd_sel   = sel;
`endif
        chk("cmd_ready_idle", {63'b0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_data  = $urandom;
        cmd_we    = $urandom_range(0, 1);

        k = 0;
        while (wb_cyc_out && k < 40) begin
            chk("bus_ctl", {59'b0, wb_cyc_out, wb_stb_out, wb_we_out, cmd_ready, rsp_valid},
                {59'b0, 1'b1, 1'b1, we, 1'b0, 1'b0});
            chk("bus_addr_data", {wb_addr_out, wb_data_out}, {addr, data});
`ifdef ZUBE_WB_INIT_SEL_EN
            chk("bus_sel", {60'b0, wb_sel_out}, {60'b0, sel});
`endif
            wb_ack_in  = (k == ack_dly);
            wb_data_in = (k == ack_dly) ? rdata : $urandom;
            @(posedge clk); #1;
            k++;
        end
        wb_ack_in = 1'b0;
        chk("bus_cycles", 64'(k), 64'(term + 1));
        chk("stb_low", {63'b0, wb_stb_out}, 64'd0);
        chk("rsp", {30'b0, rsp_valid, rsp_err, rsp_data}, {30'b0, 1'b1, exp_err, exp_data});

        stable = 1'b1;
        rsp_snap = {rsp_valid, rsp_err, rsp_data};
        for (int i = 0; i < hold; i++) begin
            // Spurious acks while waiting must be ignored.
            wb_ack_in  = $urandom_range(0, 1);
            wb_data_in = $urandom;
            @(posedge clk); #1;
            if ({rsp_valid, rsp_err, rsp_data} !== rsp_snap || cmd_ready !== 1'b0 ||
                wb_cyc_out !== 1'b0) stable = 1'b0;
        end
        wb_ack_in = 1'b0;
        if (hold > 0) chk("rsp_hold_stable", {63'b0, stable}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", {62'b0, rsp_valid, cmd_ready}, 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        int          d;
        logic [31:0] a, wd, rd;
        logic [3:0]  s;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
`ifdef ZUBE_WB_INIT_SEL_EN
        cmd_sel    = 4'hF;
`endif
        rsp_ready  = 1'b0;
        wb_ack_in  = 1'b0;
        wb_data_in = '0;

        #12;
        chk("reset_ctl", {59'b0, wb_cyc_out, wb_stb_out, wb_we_out, rsp_valid, rsp_err}, 64'd0);
        chk("reset_bus", {wb_addr_out, wb_data_out}, 64'd0);
        chk("reset_rsp_data", {32'b0, rsp_data}, 64'd0);
`ifdef ZUBE_WB_INIT_SEL_EN
        chk("reset_sel", {60'b0, wb_sel_out}, 64'hF);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", {63'b0, cmd_ready}, 64'd1);

        // Write acked on first bus cycle.
        do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h5555_AAAA, 0);
        // Read with 4 wait states.
        do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 4, 32'h1234_5678, 0);
        // Slave never acks: timeout.
        do_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, -1, 32'hFFFF_FFFF, 0);
        // Next command after a timeout runs normally.
        do_txn(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 0);
        // Ack on the exact timeout cycle wins.
        do_txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, TO - 1, 32'h0BAD_CAFE, 0);
        // Ack one cycle too late is a timeout.
        do_txn(1'b0, 32'h3000_0018, 32'h0, 4'hF, TO, 32'h0BAD_CAFE, 0);
        // Response held for 10 cycles.
        do_txn(1'b0, 32'h3000_001C, 32'h0, 4'hF, 2, 32'h8765_4321, 10);

        // Spurious ack in IDLE changes nothing.
        @(negedge clk);
        wb_ack_in  = 1'b1;
        wb_data_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        wb_ack_in = 1'b0;
        chk("idle_spurious_ack", {32'b0, rsp_data}, {32'b0, 32'h8765_4321});
        chk("idle_spurious_ctl", {60'b0, wb_cyc_out, wb_stb_out, rsp_valid, cmd_ready}, 64'b0001);

`ifdef ZUBE_WB_INIT_SEL_EN
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'b0011, 0, 32'hAABB_CCDD, 0);
        chk("sel_read_data_value", {32'b0, 32'h0000_CCDD}, {32'b0, 32'hAABB_CCDD & 32'h0000_FFFF});
`endif

        // Reset during BUS.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h3000_0040;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_cyc", {63'b0, wb_cyc_out}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_reset_ctl", {61'b0, wb_cyc_out, wb_stb_out, rsp_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h1357_9BDF, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            w  = $urandom_range(0, 1);
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            s  = 4'($urandom_range(0, 15));
            d  = $urandom_range(0, 11);
            if (d >= 10) d = -1;
            do_txn(w, a, wd, s, d, rd, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
